vec_addr_seq: RTL and testbench

Parametrised address sequencer for the activation memory. It accepts a command naming two vectors, a start element index and an element count. It then streams one physical address pair per cycle over a valid/ready handshake, mapping each element index into the banked main region or the packed overflow region. It sits between the layer controller and the dual-port activation RAM and replaces hand-coded per-vector address maps.

---
 rtl/vec_mem_pkg.sv | 34 +++
 rtl/vec_loc_map.sv | 48 ++++
 rtl/vec_addr_seq.sv | 238 +++++++++++++++++++++++
 tb/tb_vec_addr_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vec_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vec_mem_pkg                                                     |
// | Purpose  : Shared constants, FSM state type and helper function for the    |
// |            activation-memory vector address sequencer.                     |
// | Contents : NUM_VEC/MAIN_DEPTH/OVF_DEPTH defaults, OVF_BASE, TOTAL_ELEMS,    |
// |            VEC_W, seq_state_t, vec_w().                                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package vec_mem_pkg;

    localparam int NUM_VEC_DEF    = 3;
    localparam int MAIN_DEPTH_DEF = 256;
    localparam int OVF_DEPTH_DEF  = 8;

    // First address of the packed overflow region (directly after all main slices).
    localparam int OVF_BASE    = NUM_VEC_DEF * MAIN_DEPTH_DEF;
    // Highest legal element index is TOTAL_ELEMS-1.
    localparam int TOTAL_ELEMS = MAIN_DEPTH_DEF + OVF_DEPTH_DEF;

    // Vector-id width; never narrower than one bit so a single-vector build still has a port.
    function automatic int vec_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int VEC_W = vec_w(NUM_VEC_DEF);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/vec_loc_map.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vec_loc_map                                                     |
// | Purpose  : Combinational (element index, vector id) -> physical address.   |
// |            Indices below MAIN_DEPTH live in the vector's main slice;       |
// |            the rest live in the vector's slot of the overflow region.      |
// | Ports    : i_idx  [IDX_W:0]    element index                              |
// |            i_vec  [VEC_W-1:0]  vector id                                  |
// |            o_addr [ADDR_W-1:0] physical RAM address                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module vec_loc_map #(
    parameter int ADDR_W     = 10,
    parameter int IDX_W      = 9,
    parameter int VEC_W      = 2,
    parameter int NUM_VEC    = 3,
    parameter int MAIN_DEPTH = 256,
    parameter int OVF_DEPTH  = 8
) (
    input  logic [IDX_W:0]    i_idx,
    input  logic [VEC_W-1:0]  i_vec,
    output logic [ADDR_W-1:0] o_addr
);

    localparam logic [IDX_W:0]    c_MAIN_IDX   = (IDX_W+1)'(MAIN_DEPTH);
    localparam logic [ADDR_W-1:0] c_MAIN_A     = ADDR_W'(MAIN_DEPTH);
    localparam logic [ADDR_W-1:0] c_OVF_A      = ADDR_W'(OVF_DEPTH);
    localparam logic [ADDR_W-1:0] c_OVF_BASE_A = ADDR_W'(NUM_VEC * MAIN_DEPTH);

    logic [ADDR_W-1:0] w_vec_a;
    logic [ADDR_W-1:0] w_idx_a;
    logic [ADDR_W-1:0] w_ovf_off;

    assign w_vec_a   = ADDR_W'(i_vec);
    assign w_idx_a   = ADDR_W'(i_idx);
    assign w_ovf_off = w_idx_a - c_MAIN_A;

    always_comb begin
        o_addr = '0;
        if (i_idx < c_MAIN_IDX) begin
            o_addr = w_vec_a * c_MAIN_A + w_idx_a;
        end else begin
            o_addr = c_OVF_BASE_A + w_vec_a * c_OVF_A + w_ovf_off;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vec_addr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vec_addr_seq                                                    |
// | Purpose  : Accepts (vec_a, vec_b, start, len) commands and streams one     |
// |            physical address pair per cycle to the dual-port activation    |
// |            RAM over a valid/ready handshake. Illegal commands produce a   |
// |            one-cycle cmd_err pulse and no addresses.                      |
// | Ports    : clk, rst_n (synchronous, active-low)                            |
// |            cmd_valid/cmd_ready, cmd_vec_a, cmd_vec_b, cmd_start, cmd_len,  |
// |            [cmd_stride], cmd_err                                           |
// |            addr_valid/addr_ready, addr_a, addr_b, addr_idx, addr_last      |
// | Config   : VEC_ADDR_SEQ_STRIDE_EN adds cmd_stride (stride 0 rejected);     |
// |            otherwise the stride is fixed at 1.                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module vec_addr_seq
    import vec_mem_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int IDX_W      = 9,
    parameter int NUM_VEC    = NUM_VEC_DEF,
    parameter int MAIN_DEPTH = MAIN_DEPTH_DEF,
    parameter int OVF_DEPTH  = OVF_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [vec_w(NUM_VEC)-1:0]   cmd_vec_a,
    input  logic [vec_w(NUM_VEC)-1:0]   cmd_vec_b,
    input  logic [IDX_W-1:0]            cmd_start,
    input  logic [IDX_W-1:0]            cmd_len,
`ifdef VEC_ADDR_SEQ_STRIDE_EN
    input  logic [IDX_W-1:0]            cmd_stride,
`endif
    output logic                        cmd_err,
    output logic                        addr_valid,
    input  logic                        addr_ready,
    output logic [ADDR_W-1:0]           addr_a,
    output logic [ADDR_W-1:0]           addr_b,
    output logic [IDX_W-1:0]            addr_idx,
    output logic                        addr_last
);

    localparam int c_VEC_W = vec_w(NUM_VEC);
    localparam int c_TOTAL = MAIN_DEPTH + OVF_DEPTH;

    localparam logic [IDX_W-1:0]   c_ONE     = IDX_W'(1);
    localparam logic [IDX_W-1:0]   c_TWO     = IDX_W'(2);
    localparam logic [c_VEC_W:0]   c_NUM_VEC = (c_VEC_W+1)'(NUM_VEC);

    seq_state_t r_state;
    seq_state_t w_state_nxt;

    logic [c_VEC_W-1:0] r_vec_a;
    logic [c_VEC_W-1:0] r_vec_b;
    logic [IDX_W:0]     r_idx;
    logic [IDX_W-1:0]   r_rem;
    logic [ADDR_W-1:0]  r_addr_a;
    logic [ADDR_W-1:0]  r_addr_b;
    logic               r_addr_valid;
    logic               r_addr_last;
    logic               r_cmd_err;

    logic               w_cmd_ready;
    logic               w_accept;
    logic               w_reject;
    logic               w_beat;
    logic               w_bad;
    logic               w_end_bad;
    logic               w_stride_bad;
    logic               w_vec_bad;
    logic [IDX_W-1:0]   w_len_m1;
    logic [IDX_W:0]     w_stride_ext;
    logic [IDX_W:0]     w_idx_nxt;
    logic [IDX_W:0]     w_map_idx;
    logic [c_VEC_W-1:0] w_map_va;
    logic [c_VEC_W-1:0] w_map_vb;
    logic [ADDR_W-1:0]  w_map_a;
    logic [ADDR_W-1:0]  w_map_b;

    // ---------------- command validation ----------------
    // len-1 is only meaningful when len != 0; len == 0 is rejected separately.
    assign w_len_m1  = cmd_len - c_ONE;
    assign w_vec_bad = ({1'b0, cmd_vec_a} >= c_NUM_VEC) || ({1'b0, cmd_vec_b} >= c_NUM_VEC);

`ifdef VEC_ADDR_SEQ_STRIDE_EN
    logic [IDX_W-1:0]   r_stride;
    logic [2*IDX_W-1:0] w_span;
    logic [2*IDX_W:0]   w_end;

    // Full-width product so a large stride cannot wrap back into range.
    assign w_span       = (2*IDX_W)'(w_len_m1) * (2*IDX_W)'(cmd_stride);
    assign w_end        = (2*IDX_W+1)'(cmd_start) + (2*IDX_W+1)'(w_span);
    assign w_end_bad    = (w_end >= (2*IDX_W+1)'(c_TOTAL));
    assign w_stride_bad = (cmd_stride == '0);
    assign w_stride_ext = {1'b0, r_stride};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stride <= '0;
        end else if (w_accept) begin
            r_stride <= cmd_stride;
        end
    end
`else
    logic [IDX_W:0] w_end;

    // One extra bit keeps start + len - 1 from wrapping.
    assign w_end        = {1'b0, cmd_start} + {1'b0, w_len_m1};
    assign w_end_bad    = (w_end >= (IDX_W+1)'(c_TOTAL));
    assign w_stride_bad = 1'b0;
    assign w_stride_ext = (IDX_W+1)'(1);
`endif

    assign w_bad = (cmd_len == '0) || w_vec_bad || w_end_bad || w_stride_bad;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_beat      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (w_bad) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (addr_ready) begin
                    w_beat = 1'b1;
                    if (r_addr_last) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- address generation ----------------
    // In IDLE the mappers see the incoming command so the first pair is ready
    // at accept; in RUN they see the next index so the output register can
    // advance in the same cycle as the handshake.
    assign w_idx_nxt = r_idx + w_stride_ext;
    assign w_map_idx = (r_state == ST_IDLE) ? {1'b0, cmd_start} : w_idx_nxt;
    assign w_map_va  = (r_state == ST_IDLE) ? cmd_vec_a : r_vec_a;
    assign w_map_vb  = (r_state == ST_IDLE) ? cmd_vec_b : r_vec_b;

    vec_loc_map #(
        .ADDR_W     (ADDR_W),
        .IDX_W      (IDX_W),
        .VEC_W      (c_VEC_W),
        .NUM_VEC    (NUM_VEC),
        .MAIN_DEPTH (MAIN_DEPTH),
        .OVF_DEPTH  (OVF_DEPTH)
    ) u_map_a (
        .i_idx  (w_map_idx),
        .i_vec  (w_map_va),
        .o_addr (w_map_a)
    );

    vec_loc_map #(
        .ADDR_W     (ADDR_W),
        .IDX_W      (IDX_W),
        .VEC_W      (c_VEC_W),
        .NUM_VEC    (NUM_VEC),
        .MAIN_DEPTH (MAIN_DEPTH),
        .OVF_DEPTH  (OVF_DEPTH)
    ) u_map_b (
        .i_idx  (w_map_idx),
        .i_vec  (w_map_vb),
        .o_addr (w_map_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vec_a      <= '0;
            r_vec_b      <= '0;
            r_idx        <= '0;
            r_rem        <= '0;
            r_addr_a     <= '0;
            r_addr_b     <= '0;
            r_addr_valid <= 1'b0;
            r_addr_last  <= 1'b0;
            r_cmd_err    <= 1'b0;
        end else begin
            r_cmd_err <= w_reject;
            if (w_accept) begin
                r_vec_a      <= cmd_vec_a;
                r_vec_b      <= cmd_vec_b;
                r_idx        <= {1'b0, cmd_start};
                r_rem        <= cmd_len;
                r_addr_a     <= w_map_a;
                r_addr_b     <= w_map_b;
                r_addr_valid <= 1'b1;
                r_addr_last  <= (cmd_len == c_ONE);
            end else if (w_beat) begin
                if (r_addr_last) begin
                    r_addr_valid <= 1'b0;
                    r_addr_last  <= 1'b0;
                end else begin
                    r_idx       <= w_idx_nxt;
                    r_rem       <= r_rem - c_ONE;
                    r_addr_a    <= w_map_a;
                    r_addr_b    <= w_map_b;
                    r_addr_last <= (r_rem == c_TWO);
                end
            end
        end
    end

    assign cmd_ready  = w_cmd_ready;
    assign cmd_err    = r_cmd_err;
    assign addr_valid = r_addr_valid;
    assign addr_a     = r_addr_a;
    assign addr_b     = r_addr_b;
    assign addr_idx   = r_idx[IDX_W-1:0];
    assign addr_last  = r_addr_last;

endmodule
`default_nettype wire

// File: tb/tb_vec_addr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vec_addr_seq                                                 |
// | Purpose  : Directed self-checking bench for vec_addr_seq. Inputs change    |
// |            on the falling edge, outputs are sampled on the falling edge.   |
// | Config   : VEC_ADDR_SEQ_STRIDE_EN enables the strided command cases.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_vec_addr_seq;

    localparam int ADDR_W = 10;
    localparam int IDX_W  = 9;
    localparam int VEC_W  = 2;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [VEC_W-1:0]  cmd_vec_a;
    logic [VEC_W-1:0]  cmd_vec_b;
    logic [IDX_W-1:0]  cmd_start;
    logic [IDX_W-1:0]  cmd_len;
    logic [IDX_W-1:0]  cmd_stride;
    logic              cmd_err;
    logic              addr_valid;
    logic              addr_ready;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [IDX_W-1:0]  addr_idx;
    logic              addr_last;

    int n_checks = 0;
    int n_errors = 0;

    vec_addr_seq #(
        .ADDR_W     (ADDR_W),
        .IDX_W      (IDX_W),
        .NUM_VEC    (3),
        .MAIN_DEPTH (256),
        .OVF_DEPTH  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_vec_a  (cmd_vec_a),
        .cmd_vec_b  (cmd_vec_b),
        .cmd_start  (cmd_start),
        .cmd_len    (cmd_len),
`ifdef VEC_ADDR_SEQ_STRIDE_EN
        .cmd_stride (cmd_stride),
`endif
        .cmd_err    (cmd_err),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .addr_idx   (addr_idx),
        .addr_last  (addr_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: checks the pair currently presented.
    task automatic beat(input string tag, input int a, input int b, input int idx, input bit last);
        check({tag, ".valid"}, 32'(addr_valid), 32'd1);
        check({tag, ".a"},     32'(addr_a),     32'(a));
        check({tag, ".b"},     32'(addr_b),     32'(b));
        check({tag, ".idx"},   32'(addr_idx),   32'(idx));
        check({tag, ".last"},  32'(addr_last),  32'(last));
    endtask

    task automatic idle_chk(input string tag);
        check({tag, ".ready"}, 32'(cmd_ready),  32'd1);
        check({tag, ".valid"}, 32'(addr_valid), 32'd0);
        check({tag, ".err"},   32'(cmd_err),    32'd0);
    endtask

    // Presents a command at a falling edge, holds it across one rising edge,
    // and returns at the next falling edge with cmd_valid dropped.
    task automatic send(input int va, input int vb, input int start, input int len, input int stride);
        cmd_vec_a  = VEC_W'(va);
        cmd_vec_b  = VEC_W'(vb);
        cmd_start  = IDX_W'(start);
        cmd_len    = IDX_W'(len);
        cmd_stride = IDX_W'(stride);
        cmd_valid  = 1'b1;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    task automatic reject(input string tag, input int va, input int vb, input int start, input int len, input int stride);
        send(va, vb, start, len, stride);
        check({tag, ".err"},   32'(cmd_err),    32'd1);
        check({tag, ".valid"}, 32'(addr_valid), 32'd0);
        @(negedge clk);
        idle_chk({tag, ".after"});
    endtask

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_vec_a  = '0;
        cmd_vec_b  = '0;
        cmd_start  = '0;
        cmd_len    = '0;
        cmd_stride = '0;
        addr_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.valid", 32'(addr_valid), 32'd0);
        check("rst.err",   32'(cmd_err),    32'd0);
        check("rst.last",  32'(addr_last),  32'd0);
        check("rst.a",     32'(addr_a),     32'd0);
        check("rst.b",     32'(addr_b),     32'd0);
        check("rst.idx",   32'(addr_idx),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        idle_chk("rst.idle");

        // Main/overflow boundary, continuous ready
        addr_ready = 1'b1;
        send(0, 1, 254, 4, 1);
        beat("t1.b0", 254, 510, 254, 1'b0);
        @(negedge clk);
        beat("t1.b1", 255, 511, 255, 1'b0);
        @(negedge clk);
        beat("t1.b2", 768, 776, 256, 1'b0);
        @(negedge clk);
        beat("t1.b3", 769, 777, 257, 1'b1);
        @(negedge clk);
        idle_chk("t1.end");

        // Same command with back-pressure: ready 1,0,0,1,1,0,1
        addr_ready = 1'b0;
        send(0, 1, 254, 4, 1);
        beat("t2.b0", 254, 510, 254, 1'b0);
        addr_ready = 1'b1;
        @(negedge clk);
        beat("t2.b1", 255, 511, 255, 1'b0);
        addr_ready = 1'b0;
        @(negedge clk);
        beat("t2.b1h", 255, 511, 255, 1'b0);
        @(negedge clk);
        beat("t2.b1h2", 255, 511, 255, 1'b0);
        check("t2.busy", 32'(cmd_ready), 32'd0);
        addr_ready = 1'b1;
        @(negedge clk);
        beat("t2.b2", 768, 776, 256, 1'b0);
        @(negedge clk);
        beat("t2.b3", 769, 777, 257, 1'b1);
        addr_ready = 1'b0;
        @(negedge clk);
        beat("t2.b3h", 769, 777, 257, 1'b1);
        addr_ready = 1'b1;
        @(negedge clk);
        idle_chk("t2.end");

        // Illegal commands
        reject("t3.len0",  0, 1, 0,   0, 1);
        reject("t3.veca3", 3, 0, 0,   4, 1);
        reject("t3.vecb3", 0, 3, 0,   4, 1);
        reject("t3.end264", 0, 1, 260, 5, 1);

        // Last legal element, identical vectors, single beat
        send(2, 2, 263, 1, 1);
        beat("t4.b0", 791, 791, 263, 1'b1);
        check("t4.err", 32'(cmd_err), 32'd0);
        @(negedge clk);
        idle_chk("t4.end");

        // Reset during the second beat of a len-8 command
        send(0, 1, 0, 8, 1);
        beat("t5.b0", 0, 256, 0, 1'b0);
        @(negedge clk);
        beat("t5.b1", 1, 257, 1, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5.rst.valid", 32'(addr_valid), 32'd0);
        check("t5.rst.a",     32'(addr_a),     32'd0);
        check("t5.rst.b",     32'(addr_b),     32'd0);
        check("t5.rst.idx",   32'(addr_idx),   32'd0);
        check("t5.rst.last",  32'(addr_last),  32'd0);
        check("t5.rst.ready", 32'(cmd_ready),  32'd1);
        send(1, 0, 10, 2, 1);
        beat("t5.n0", 266, 10, 10, 1'b0);
        @(negedge clk);
        beat("t5.n1", 267, 11, 11, 1'b1);
        @(negedge clk);
        idle_chk("t5.end");

`ifdef VEC_ADDR_SEQ_STRIDE_EN
        // Strided walk crossing into overflow
        send(2, 2, 0, 3, 128);
        beat("t6.b0", 512, 512, 0,   1'b0);
        @(negedge clk);
        beat("t6.b1", 640, 640, 128, 1'b0);
        @(negedge clk);
        beat("t6.b2", 784, 784, 256, 1'b1);
        @(negedge clk);
        idle_chk("t6.end");
        reject("t6.stride0", 0, 0, 0, 3, 0);
        // end = 0 + 2*132 = 264, one past the last element
        reject("t6.endovf", 0, 0, 0, 3, 132);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
